// File: rtl/s2p_pkg.sv
// Shared definitions for the serial link pair (p2s / s2p).
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
// Contents: cnt_w() bit-counter width helper, bit_order_e serial bit order.
package s2p_pkg;

  // Width of a counter that indexes bits 0..n-1 of an n-bit word.
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

  // Serial bit order; p2s and s2p must agree on this.
  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_e;

endpackage

// File: rtl/word_reg.sv
// N-bit valid/ready output holding register with load and pop.
// Latency: a load is visible on data/valid right after the loading edge.
// Backpressure: data is held while valid && !ready; valid drops on a pop with no load.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   load, load_data  : write a new word (takes priority over a pop on the same edge)
//   ready            : consumer accepts the held word this cycle
//   data, valid      : registered word and its valid flag
module word_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         ready,
  output logic [N-1:0] data,
  output logic         valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/s2p.sv
// Serial-to-parallel deserializer: assembles N serial bits into a word on a valid/ready output.
// Latency: the word is on p_data/p_valid right after the edge accepting its Nth bit.
// Backpressure: one completed word is parked in the shift register while the output is full;
//   s_ready drops only then, so the link streams as long as each word is popped within N cycles.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   s_data, s_valid, s_ready  : serial bit handshake
//   p_data, p_valid, p_ready  : parallel word handshake (p_data/p_valid registered)
module s2p
  import s2p_pkg::*;
#(
  parameter int N         = 8,  // word width, at least 2
  parameter bit MSB_FIRST = 0   // 1: first serial bit lands in p_data[N-1]
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [N-1:0] p_data,
  output logic         p_valid,
  input  logic         p_ready
);

  localparam int            CW       = cnt_w(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [N-1:0]  sh;
  logic [N-1:0]  sh_next;
  logic [CW-1:0] cnt;
  logic          sh_full;
  logic          accept;
  logic          word_done;
  logic          pop;
  logic          out_free;
  logic          load;
  logic [N-1:0]  load_data;

  // sh_full only ever holds a finished word, so no further bit may enter.
  assign s_ready   = !rst && !sh_full;
  assign accept    = s_valid && s_ready;
  assign word_done = accept && (cnt == CNT_LAST);
  assign pop       = p_valid && p_ready;
  // Output register can take a word this edge: empty, or its word leaves now.
  assign out_free  = !p_valid || p_ready;

  // Shift direction is chosen so the first bit ends at index 0 (LSB first)
  // or N-1 (MSB first) after N shifts.
  generate
    if (MSB_FIRST) begin : g_msb
      assign sh_next = {sh[N-2:0], s_data};
    end else begin : g_lsb
      assign sh_next = {s_data, sh[N-1:1]};
    end
  endgenerate

  // A completing word goes straight to the output when possible; a parked
  // word moves out on the first pop. The two cannot coincide because no bit
  // is accepted while a word is parked.
  assign load      = (word_done && out_free) || (sh_full && pop);
  assign load_data = sh_full ? sh : sh_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '0;
      cnt     <= '0;
      sh_full <= 1'b0;
    end else begin
      if (accept) begin
        sh  <= sh_next;
        cnt <= word_done ? '0 : cnt + CW'(1);
      end
      if (word_done && !out_free) begin
        sh_full <= 1'b1;
      end else if (sh_full && pop) begin
        sh_full <= 1'b0;
      end
    end
  end

  word_reg #(.N(N)) u_word_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .ready     (p_ready),
    .data      (p_data),
    .valid     (p_valid)
  );

endmodule
